s_res_sched: RTL
================

Name: s_res_sched

Overview:
S-register result scheduler. It consumes the per-instruction result latency and source code (o_delay/o_src/o_s_dest_en from the S result look-up table) and counts each result down in a slot shift-register. When a result's time arrives, it drives the S write-enable, the destination register address and the SBUS source-mux select.
It also gives issue control a per-register busy vector and a same-cycle slot-conflict flag for stall decisions. It sits between the instruction issue stage and the S-register file write port.

Parameters:
DEPTH, 15, number of delay slots; equals the maximum schedulable delay.
SRC_W, 5, width of the SBUS source code.
ADDR_W, 3, S-register address width (S0-S7).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; one clock, asynchronous, active-high.
i_issue  in  1  instruction issues this cycle.
i_dest_en  in  1  the issuing instruction writes an S register.
i_delay  in  4  cycles from issue to result (1..DEPTH).
i_src  in  SRC_W  SBUS source for the result.
i_dest  in  ADDR_W  destination S register (the i field).
i_clear  in  1  synchronous flush of all pending results (exchange/abort).
o_conflict  out  1  combinational: the requested slot is taken, so the issue must stall.
o_wr_en  out  1  write S register this cycle.
o_wr_addr  out  ADDR_W  S register being written.
o_sbus_sel  out  SRC_W  SBUS mux select; SBUS_NONE when o_wr_en=0.
o_s_busy  out  8  bit r set while any pending result targets Sr.
o_err  out  1  one-cycle pulse: a scheduled issue carried i_delay=0.

Behaviour:
- Storage: slot[0..DEPTH-1], each holding {valid, src, dest}. Slot k retires k+1 edges after it is loaded.
- Every rising edge: slot[k] <= slot[k+1] for k=0..DEPTH-2, and slot[DEPTH-1] <= invalid.
- Accept condition: a schedule request is i_issue & i_dest_en & (i_delay!=0). It is accepted when o_conflict=0.
- On accept: slot[i_delay-1] <= {1, i_src, i_dest}. This overrides the shifted-in value.
- Conflict rule: o_conflict = request & slot[i_delay].valid for i_delay<DEPTH.
  - The check uses current slot[i_delay], because that entry shifts into slot[i_delay-1] on the same edge.
  - i_delay=DEPTH never conflicts.
- A conflicted request is dropped with no state change. Issue control must hold the instruction and re-present it next cycle.
- i_delay=0 with i_issue & i_dest_en: nothing is scheduled; o_err pulses high the next cycle.
- Requests with i_dest_en=0 are ignored and never raise o_conflict.
- Outputs are registered from slot[0]:
  - o_wr_en = slot[0].valid.
  - o_wr_addr = slot[0].dest.
  - o_sbus_sel = slot[0].valid ? slot[0].src : SBUS_NONE.
- Latency: i_issue sampled at edge E with i_delay=d puts o_wr_en high for exactly the cycle after edge E+d-1, i.e. d cycles after the issue cycle.
- o_s_busy (combinational from slot state): bit r = OR over k of (slot[k].valid & slot[k].dest==r). It is set from the cycle after accept up to and including the o_wr_en cycle.
- WAW: multiple pending writes to the same Sr are permitted. Busy stays set until the last one retires, and writes retire in slot order.
- Writes from different issue cycles can never retire in the same cycle, because the conflict rule reserves each retirement slot. This guarantees a single write port.
- i_clear: on the next edge every slot and o_wr_en are invalidated and o_sbus_sel becomes SBUS_NONE. i_clear overrides a simultaneous accept. o_conflict is still computed from current state.
- Reset (async assert, sync release): all slots invalid, o_wr_en=0, o_wr_addr=0, o_sbus_sel=SBUS_NONE, o_s_busy=0, o_err=0.
- Reset asserted mid-countdown discards every pending result; no write occurs after release.

Decomposition:
- SBUS_* source codes (including SBUS_NONE) stay in cray_types.vh; this block includes that file and adds no new codes.
- DEPTH is shared with the latency look-up table's max delay (14 today, DEPTH=15 gives one spare).
- One sub-module is natural: s_res_slot, a single slot register with load/shift/clear muxing, instantiated DEPTH times in a generate loop. Busy OR-reduction and output registers stay in the top.

Test Plan:
- Issue 040 (d=1, src=SBUS_IMM, dest=S3) at cycle 0 -> o_wr_en=1, o_wr_addr=3, o_sbus_sel=SBUS_IMM at cycle 1 only; o_s_busy=8'h08 at cycle 1, 0 at cycle 2.
- Issue 070 (d=14, dest=S5) at cycle 0, then 062 (d=6, dest=S1) at cycle 8 -> o_conflict=1 at cycle 8, nothing scheduled; the same 062 re-presented at cycle 9 is accepted and written at cycle 15, and S5 is written at cycle 14.
- Issue 064 (d=7, dest=S2) at cycle 0 and 052 (d=2, dest=S2) at cycle 1 -> writes at cycles 3 and 7; o_s_busy[2]=1 from cycle 1 through 7.
- Issue with i_delay=0, i_dest_en=1 -> no write, o_err pulse next cycle; i_dest_en=0 with d=11 -> no write, o_conflict=0.
- Issue 120 (d=11, src=SBUS_MEM) at cycle 0, i_clear at cycle 4 -> no write at cycle 11; o_s_busy=0 from cycle 5.
- Assert rst asynchronously at cycle 3 with three pending results -> all outputs zero/SBUS_NONE immediately; no writes after release.

Source files
------------

// File: rtl/s_res_sched_pkg.sv
// Shared constants for the S-register result scheduler: SBUS source codes,
// default geometry and a small delay-width helper.
package s_res_sched_pkg;

    // Default geometry. SCHED_DEPTH tracks the latency LUT maximum (14) plus one spare slot.
    localparam int unsigned SBUS_W      = 5;
    localparam int unsigned SREG_AW     = 3;
    localparam int unsigned SCHED_DEPTH = 15;

    typedef logic [SBUS_W-1:0] sbus_code_t;

    // SBUS source codes. SBUS_NONE is what the mux selects when no S write is pending.
    localparam sbus_code_t SBUS_NONE  = 5'd0;
    localparam sbus_code_t SBUS_IMM   = 5'd1;
    localparam sbus_code_t SBUS_SJ    = 5'd2;
    localparam sbus_code_t SBUS_ADD   = 5'd3;
    localparam sbus_code_t SBUS_LOG   = 5'd4;
    localparam sbus_code_t SBUS_SHIFT = 5'd5;
    localparam sbus_code_t SBUS_POP   = 5'd6;
    localparam sbus_code_t SBUS_MEM   = 5'd7;
    localparam sbus_code_t SBUS_RTC   = 5'd8;
    localparam sbus_code_t SBUS_VM    = 5'd9;
    localparam sbus_code_t SBUS_FADD  = 5'd10;
    localparam sbus_code_t SBUS_FMUL  = 5'd11;
    localparam sbus_code_t SBUS_RECIP = 5'd12;

    // Bits needed to express a delay of 0..depth.
    function automatic int unsigned delay_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/s_res_sched_if.sv
// Issue-side and write-port signals of the S result scheduler.
// master = issue control / S-register file, slave = the scheduler.
interface s_res_sched_if
    import s_res_sched_pkg::*;
#(
    parameter int unsigned SRC_W  = SBUS_W,
    parameter int unsigned ADDR_W = SREG_AW,
    parameter int unsigned DLY_W  = delay_width(SCHED_DEPTH)
) ();

    // Issue request
    logic                    i_issue;
    logic                    i_dest_en;
    logic [DLY_W-1:0]        i_delay;
    logic [SRC_W-1:0]        i_src;
    logic [ADDR_W-1:0]       i_dest;
    logic                    i_clear;

    // Issue feedback
    logic                    o_conflict;
    logic [(1<<ADDR_W)-1:0]  o_s_busy;
    logic                    o_err;

    // S-register write port
    logic                    o_wr_en;
    logic [ADDR_W-1:0]       o_wr_addr;
    logic [SRC_W-1:0]        o_sbus_sel;

    modport master (
        output i_issue, i_dest_en, i_delay, i_src, i_dest, i_clear,
        input  o_conflict, o_s_busy, o_err, o_wr_en, o_wr_addr, o_sbus_sel
    );

    modport slave (
        input  i_issue, i_dest_en, i_delay, i_src, i_dest, i_clear,
        output o_conflict, o_s_busy, o_err, o_wr_en, o_wr_addr, o_sbus_sel
    );

endinterface

// File: rtl/s_res_slot.sv
// One delay slot of the result scheduler: holds {valid, src, dest} and either
// takes a new result, shifts in its upstream neighbour, or is flushed.
module s_res_slot
    import s_res_sched_pkg::*;
#(
    parameter int unsigned      SRC_W    = SBUS_W,
    parameter int unsigned      ADDR_W   = SREG_AW,
    parameter logic [SRC_W-1:0] SRC_NONE = SRC_W'(SBUS_NONE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [SRC_W-1:0]  i_load_src,
    input  logic [ADDR_W-1:0] i_load_dest,
    input  logic              i_shift_valid,
    input  logic [SRC_W-1:0]  i_shift_src,
    input  logic [ADDR_W-1:0] i_shift_dest,
    output logic              o_valid,
    output logic [SRC_W-1:0]  o_src,
    output logic [ADDR_W-1:0] o_dest
);

    logic              r_valid;
    logic [SRC_W-1:0]  r_src;
    logic [ADDR_W-1:0] r_dest;

    // Flush beats load, load beats shift; empty slots always hold {NONE, 0}.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_src   <= SRC_NONE;
            r_dest  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_src   <= SRC_NONE;
            r_dest  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_src   <= i_load_src;
            r_dest  <= i_load_dest;
        end else begin
            r_valid <= i_shift_valid;
            r_src   <= i_shift_src;
            r_dest  <= i_shift_dest;
        end
    end

    assign o_valid = r_valid;
    assign o_src   = r_src;
    assign o_dest  = r_dest;

endmodule

// File: rtl/s_res_sched.sv
// S-register result scheduler. Each accepted result is dropped into the slot
// matching its latency and marches down to slot 0, which drives the S write
// port. Issue control gets a slot-conflict stall flag and a per-register busy map.
module s_res_sched
    import s_res_sched_pkg::*;
#(
    parameter int unsigned DEPTH  = SCHED_DEPTH,
    parameter int unsigned SRC_W  = SBUS_W,
    parameter int unsigned ADDR_W = SREG_AW
) (
    input  logic         clk,
    input  logic         rst,
    s_res_sched_if.slave bus
);

    localparam int unsigned      DLY_W  = delay_width(DEPTH);
    localparam int unsigned      NREG   = 1 << ADDR_W;
    localparam logic [SRC_W-1:0] W_NONE = SRC_W'(SBUS_NONE);

    // Index DEPTH is a permanently empty pseudo-slot feeding the top of the chain;
    // it also makes i_delay == DEPTH read back as "free" in the conflict check.
    logic [DEPTH:0]    w_valid;
    logic [SRC_W-1:0]  w_src  [DEPTH+1];
    logic [ADDR_W-1:0] w_dest [DEPTH+1];
    logic [DEPTH-1:0]  w_load;

    logic              w_request;
    logic              w_conflict;
    logic              w_accept;
    logic              w_bad_delay;
    logic [NREG-1:0]   w_busy;
    logic              r_err;

    assign w_valid[DEPTH] = 1'b0;
    assign w_src[DEPTH]   = W_NONE;
    assign w_dest[DEPTH]  = '0;

    // A request only exists for a real S write with a nonzero latency.
    assign w_request   = bus.i_issue & bus.i_dest_en & (bus.i_delay != '0);
    assign w_bad_delay = bus.i_issue & bus.i_dest_en & (bus.i_delay == '0);

    // slot[d] moves into slot[d-1] on this edge, so that is the entry we would collide with.
    assign w_conflict  = w_request & w_valid[bus.i_delay];

    // Flush wins over a same-cycle accept.
    assign w_accept    = w_request & ~w_conflict & ~bus.i_clear;

    // Slot chain: slot k shifts in slot k+1 and loads when the latency selects it.
    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        assign w_load[k] = w_accept & (bus.i_delay == DLY_W'(k + 1));

        s_res_slot #(
            .SRC_W    (SRC_W),
            .ADDR_W   (ADDR_W),
            .SRC_NONE (W_NONE)
        ) u_slot (
            .clk           (clk),
            .rst           (rst),
            .i_clear       (bus.i_clear),
            .i_load        (w_load[k]),
            .i_load_src    (bus.i_src),
            .i_load_dest   (bus.i_dest),
            .i_shift_valid (w_valid[k+1]),
            .i_shift_src   (w_src[k+1]),
            .i_shift_dest  (w_dest[k+1]),
            .o_valid       (w_valid[k]),
            .o_src         (w_src[k]),
            .o_dest        (w_dest[k])
        );
    end

    // Busy map: a register is busy while any live slot (including slot 0) targets it.
    always_comb begin
        w_busy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_valid[k]) begin
                w_busy[w_dest[k]] = 1'b1;
            end
        end
    end

    // Zero-latency S write is a decode error; flag it for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_bad_delay;
        end
    end

    assign bus.o_conflict = w_conflict;
    assign bus.o_s_busy   = w_busy;
    assign bus.o_err      = r_err;
    assign bus.o_wr_en    = w_valid[0];
    assign bus.o_wr_addr  = w_dest[0];
    assign bus.o_sbus_sel = w_valid[0] ? w_src[0] : W_NONE;

endmodule
